// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state encoding for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Slice-level function select, taken from the low two opcode bits.
    localparam logic [1:0] SLICE_AND = 2'b00;
    localparam logic [1:0] SLICE_OR  = 2'b01;
    localparam logic [1:0] SLICE_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU cell: AND, OR or full-add.
// The carry output is always the full-adder carry.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);

    always_comb begin
        r = 1'b0;
        case (op)
            SLICE_AND: r = a & b;
            SLICE_OR:  r = a | b;
            SLICE_ADD: r = a ^ b ^ cin;
            default:   r = 1'b0;
        endcase
    end

    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: walks one alu_bit_slice across W-bit operands, LSB first,
// and registers the word result and flags when the sequence completes.
module serial_alu_sequencer
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         carry_out,
    output logic         zero
);

    localparam int CNT_W = $clog2(W);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-2:0]       sum_sh;
    logic               carry;
    logic [2:0]         op_reg;
    logic               slice_r;
    logic               slice_cout;
    logic               last_bit;
    logic [W-1:0]       sum_full;
    logic               is_arith;
    logic               slice_ovf;
    logic [W-1:0]       final_result;

    alu_bit_slice u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .op   (op_reg[1:0]),
        .r    (slice_r),
        .cout (slice_cout)
    );

    assign last_bit  = (bit_cnt == CNT_W'(W - 1));
    assign sum_full  = {slice_r, sum_sh};
    assign is_arith  = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_SLT);
    // At the MSB the shift registers present a[W-1] and b_eff[W-1] to the slice.
    assign slice_ovf = (a_sh[0] == b_sh[0]) && (slice_r != a_sh[0]);

    always_comb begin
        final_result = '0;
        case (op_reg)
            OP_AND, OP_OR, OP_ADD, OP_SUB: final_result = sum_full;
            OP_SLT:  final_result = {{(W-1){1'b0}}, sum_full[W-1] ^ slice_ovf};
            default: final_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are captured only on an accepted start; a start seen while busy is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            op_reg  <= OP_AND;
        end else if (state == IDLE) begin
            if (start) begin
                bit_cnt <= '0;
                a_sh    <= a;
                b_sh    <= op[2] ? ~b : b;
                carry   <= op[2];
                op_reg  <= op;
            end
        end else if (state == RUN) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= sum_full[W-1:1];
            carry   <= slice_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (state == RUN && last_bit) begin
            result    <= final_result;
            overflow  <= is_arith && slice_ovf;
            carry_out <= is_arith && slice_cout;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zero = (result == '0);

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed self-checking bench for serial_alu_sequencer (W=4): vector table plus
// hand-written sequences for ignored restart and mid-operation reset.
module tb_serial_alu_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;
    logic         carry_out;
    logic         zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         cout;
        logic         zro;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    serial_alu_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start; returns with inputs idle, #1 after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the start-sampling edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_carry_out"}, carry_out, 0);
        check({tag, "_zero"}, zero, 1);
    endtask

    initial begin
        int lat;
        int done_pulses;

        vecs[0] = '{3'b010, 4'b0111, 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{3'b110, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{3'b110, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3'b111, 4'b1000, 4'b0111, 4'b0001, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{3'b111, 4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{3'b000, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b001, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b011, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{3'b010, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{3'b010, 4'b0100, 4'b0100, 4'b1000, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_run", i), busy, 1);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, W + 1);
            check($sformatf("v%0d_busy_done", i), busy, 1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d_carry_out", i), carry_out, vecs[i].cout);
            check($sformatf("v%0d_zero", i), zero, vecs[i].zro);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_idle", i), busy, 0);
            check($sformatf("v%0d_hold", i), result, vecs[i].res);
        end

        // Restart attempt in cycle 2 of an ADD must be ignored.
        issue(3'b010, 4'b0001, 4'b0010);
        done_pulses = 0;
        start = 1'b1;
        op    = 3'b110;
        a     = 4'b1111;
        b     = 4'b1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                done_pulses++;
                if (done_pulses == 1) begin
                    check("restart_latency", lat, W + 1);
                    check("restart_result", result, 4'b0011);
                    check("restart_overflow", overflow, 0);
                    check("restart_carry_out", carry_out, 0);
                end
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check("restart_done_count", done_pulses, 1);

        // Reset asserted in cycle 2 of a SUB clears outputs without waiting for a clock.
        issue(3'b010, 4'b0100, 4'b0100);
        wait_done(lat);
        check("pre_reset_result", result, 4'b1000);
        @(posedge clk);
        #1;
        issue(3'b110, 4'b0011, 4'b0101);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("post_release");
        issue(3'b010, 4'b0010, 4'b0011);
        wait_done(lat);
        check("after_reset_latency", lat, W + 1);
        check("after_reset_result", result, 4'b0101);
        check("after_reset_overflow", overflow, 0);
        check("after_reset_zero", zero, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
